// File: rtl/mux21_arbiter_if.sv
// Stream bundle between the two requesters, the shared 2:1 mux arbiter and the downstream consumer.
// master = producers/consumer side, slave = arbiter side.
interface mux21_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             d0_valid;
    logic [WIDTH-1:0] d0_data;
    logic             d0_last;
    logic             d0_ready;
    logic             d1_valid;
    logic [WIDTH-1:0] d1_data;
    logic             d1_last;
    logic             d1_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_last;
    logic             y_ready;
    logic             sel;
    logic             busy;

    modport master (
        output d0_valid, d0_data, d0_last, d1_valid, d1_data, d1_last, y_ready,
        input  d0_ready, d1_ready, y_valid, y_data, y_last, sel, busy
    );

    modport slave (
        input  d0_valid, d0_data, d0_last, d1_valid, d1_data, d1_last, y_ready,
        output d0_ready, d1_ready, y_valid, y_data, y_last, sel, busy
    );
endinterface

// File: rtl/mux21_arbiter.sv
// Burst-locked round-robin arbiter sharing one 2:1 mux between two valid/ready streams,
// with a one-entry registered output stage that sustains one beat per cycle.
module mux21_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux21_arbiter_if.slave    bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             prio_r;
    logic             prio_nxt_s;
    logic             y_valid_r;
    logic [WIDTH-1:0] y_data_r;
    logic             y_last_r;
    logic             sel_s;
    logic             busy_s;
    logic             out_free_s;
    logic             d0_ready_s;
    logic             d1_ready_s;
    logic             xfer_s;
    logic             xfer_last_s;
    logic [WIDTH-1:0] mux_y_s;

    function automatic logic [WIDTH-1:0] mux21(input logic s,
                                               input logic [WIDTH-1:0] d0,
                                               input logic [WIDTH-1:0] d1);
        return s ? d1 : d0;
    endfunction

    // Mux select, handshake readies and transfer detection for the granted port
    always_comb begin
        sel_s       = (state_r == ST_LOCK1);
        busy_s      = (state_r == ST_LOCK0) || (state_r == ST_LOCK1);
        out_free_s  = !y_valid_r || bus.y_ready;
        d0_ready_s  = (state_r == ST_LOCK0) && out_free_s;
        d1_ready_s  = (state_r == ST_LOCK1) && out_free_s;
        mux_y_s     = mux21(sel_s, bus.d0_data, bus.d1_data);
        xfer_s      = (bus.d0_valid && d0_ready_s) || (bus.d1_valid && d1_ready_s);
        xfer_last_s = sel_s ? bus.d1_last : bus.d0_last;
    end

    // Grant FSM; the priority pointer flips to the other port whenever a burst ends
    always_comb begin
        state_nxt_s = state_r;
        prio_nxt_s  = prio_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.d0_valid && bus.d1_valid) begin
                    state_nxt_s = prio_r ? ST_LOCK1 : ST_LOCK0;
                end else if (bus.d0_valid) begin
                    state_nxt_s = ST_LOCK0;
                end else if (bus.d1_valid) begin
                    state_nxt_s = ST_LOCK1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK0: begin
                if (xfer_s && xfer_last_s) begin
                    state_nxt_s = ST_IDLE;
                    prio_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_LOCK0;
                end
            end
            ST_LOCK1: begin
                if (xfer_s && xfer_last_s) begin
                    state_nxt_s = ST_IDLE;
                    prio_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_LOCK1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and priority pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            prio_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            prio_r  <= prio_nxt_s;
        end
    end

    // Output stage: a load wins over a drain so back-to-back beats keep y_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_r <= 1'b0;
            y_data_r  <= {WIDTH{1'b0}};
            y_last_r  <= 1'b0;
        end else if (xfer_s) begin
            y_valid_r <= 1'b1;
            y_data_r  <= mux_y_s;
            y_last_r  <= xfer_last_s;
        end else if (bus.y_ready) begin
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= y_valid_r;
        end
    end

    assign bus.d0_ready = d0_ready_s;
    assign bus.d1_ready = d1_ready_s;
    assign bus.y_valid  = y_valid_r;
    assign bus.y_data   = y_data_r;
    assign bus.y_last   = y_last_r;
    assign bus.sel      = sel_s;
    assign bus.busy     = busy_s;
endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed self-checking bench for mux21_arbiter: grant latency, round-robin order,
// backpressure, idle-requester lock and asynchronous reset mid-burst.
module tb_mux21_arbiter;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux21_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux21_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        bus.d0_valid = 1'b0;
        bus.d0_data  = 8'h00;
        bus.d0_last  = 1'b0;
        bus.d1_valid = 1'b0;
        bus.d1_data  = 8'h00;
        bus.d1_last  = 1'b0;
        bus.y_ready  = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst_n = 1'b0;
        drive_idle();
        #2;
        obs = {bus.y_valid, bus.y_last, bus.sel, bus.busy, bus.d0_ready, bus.d1_ready};
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", obs); end
        checks++;
        if (bus.y_data !== 8'h00) begin errors++; $display("FAIL reset_ydata: got %h expected 00", bus.y_data); end
        bus.d0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs = {bus.y_valid, bus.y_last, bus.sel, bus.busy, bus.d0_ready, bus.d1_ready};
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL reset_held: got %b expected 000000", obs); end
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [3:0] obs;
        bus.d0_valid = 1'b1;
        bus.d0_data  = 8'hA5;
        bus.d0_last  = 1'b1;
        bus.y_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs = {bus.busy, bus.sel, bus.d0_ready, bus.y_valid};
        checks++;
        if (obs !== 4'b1010) begin errors++; $display("FAIL single_grant: got %b expected 1010", obs); end
        @(posedge clk);
        @(negedge clk);
        bus.d0_valid = 1'b0;
        checks++;
        if ({bus.y_valid, bus.y_last, bus.y_data} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++; $display("FAIL single_y: got v=%b l=%b d=%h expected v=1 l=1 d=a5", bus.y_valid, bus.y_last, bus.y_data);
        end
        checks++;
        if ({bus.busy, dut.prio_r} !== 2'b01) begin
            errors++; $display("FAIL single_idle_prio: got busy=%b prio=%b expected busy=0 prio=1", bus.busy, dut.prio_r);
        end
        @(negedge clk);
        checks++;
        if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", bus.y_valid); end
    endtask

    task automatic test_contention(input logic first_port, input string name);
        logic [7:0] got [$];
        int         got_cyc [$];
        logic [7:0] exp_seq [6];
        int         idx0, idx1, viol;
        logic       fire0, fire1, first_done;
        idx0 = 0; idx1 = 0; viol = 0;
        if (first_port) exp_seq = '{8'h11, 8'h12, 8'h13, 8'h01, 8'h02, 8'h03};
        else            exp_seq = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13};
        bus.y_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
            bus.d0_valid = (idx0 < 3);
            bus.d0_data  = 8'h01 + 8'(idx0);
            bus.d0_last  = (idx0 == 2);
            bus.d1_valid = (idx1 < 3);
            bus.d1_data  = 8'h11 + 8'(idx1);
            bus.d1_last  = (idx1 == 2);
            #1;
            if (bus.y_valid) begin
                got.push_back(bus.y_data);
                got_cyc.push_back(cyc);
            end
            first_done = first_port ? (idx1 == 3) : (idx0 == 3);
            if (bus.d0_ready && bus.d1_ready) viol++;
            if (!first_done && (first_port ? bus.d0_ready : bus.d1_ready)) viol++;
            fire0 = bus.d0_valid && bus.d0_ready;
            fire1 = bus.d1_valid && bus.d1_ready;
            @(posedge clk);
            if (fire0) idx0++;
            if (fire1) idx1++;
            @(negedge clk);
        end
        drive_idle();
        checks++;
        if (got.size() != 6) begin errors++; $display("FAIL %s_count: got %0d expected 6", name, got.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_seq[i]) begin
                    errors++; $display("FAIL %s_beat%0d: got %h expected %h", name, i, got[i], exp_seq[i]);
                end
            end
        end
        if (got.size() == 6) begin
            checks++;
            if (got_cyc[3] - got_cyc[2] != 2) begin
                errors++; $display("FAIL %s_gap: got %0d expected 2", name, got_cyc[3] - got_cyc[2]);
            end
            checks++;
            if (got_cyc[2] - got_cyc[0] != 2) begin
                errors++; $display("FAIL %s_throughput: got %0d expected 2", name, got_cyc[2] - got_cyc[0]);
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL %s_other_ready: got %0d expected 0", name, viol); end
    endtask

    task automatic test_backpressure();
        logic [8:0] got [$];
        logic [8:0] exp_seq [4];
        logic [7:0] hold_val;
        logic       hold_seen, fire0;
        int         idx0, viol, hold_cycles;
        exp_seq = '{{1'b0, 8'hB0}, {1'b0, 8'hB1}, {1'b0, 8'hB2}, {1'b1, 8'hB3}};
        idx0 = 0; viol = 0; hold_cycles = 0; hold_seen = 1'b0; hold_val = 8'h00;
        for (int k = 0; k < 40 && got.size() < 4; k++) begin
            bus.d0_valid = (idx0 < 4);
            bus.d0_data  = 8'hB0 + 8'(idx0);
            bus.d0_last  = (idx0 == 3);
            bus.y_ready  = !(k >= 3 && k < 6);
            #1;
            if (bus.y_valid && bus.y_ready) begin
                got.push_back({bus.y_last, bus.y_data});
                hold_seen = 1'b0;
            end else if (bus.y_valid) begin
                hold_cycles++;
                if (bus.d0_ready) viol++;
                if (hold_seen && bus.y_data !== hold_val) viol++;
                hold_val  = bus.y_data;
                hold_seen = 1'b1;
            end
            fire0 = bus.d0_valid && bus.d0_ready;
            @(posedge clk);
            if (fire0) idx0++;
            @(negedge clk);
        end
        drive_idle();
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_seq[i]) begin
                    errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, got[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (hold_cycles != 3) begin errors++; $display("FAIL bp_hold_cycles: got %0d expected 3", hold_cycles); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations expected 0", viol); end
    endtask

    task automatic test_idle_requester();
        logic [2:0] obs;
        bus.y_ready  = 1'b1;
        bus.d1_valid = 1'b1;
        bus.d1_data  = 8'h55;
        bus.d1_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.d1_ready !== 1'b1) begin errors++; $display("FAIL idle_lock1_ready: got %b expected 1", bus.d1_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.y_valid, bus.y_data} !== {1'b1, 8'h55}) begin
            errors++; $display("FAIL idle_first_beat: got v=%b d=%h expected v=1 d=55", bus.y_valid, bus.y_data);
        end
        bus.d1_valid = 1'b0;
        bus.d0_valid = 1'b1;
        bus.d0_data  = 8'h77;
        bus.d0_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            obs = {bus.sel, bus.d0_ready, bus.busy};
            checks++;
            if (obs !== 3'b101) begin errors++; $display("FAIL idle_hold%0d: got %b expected 101", i, obs); end
            @(negedge clk);
        end
        bus.d1_valid = 1'b1;
        bus.d1_data  = 8'h56;
        bus.d1_last  = 1'b1;
        bus.d0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.d1_valid = 1'b0;
        checks++;
        if ({bus.y_last, bus.y_data, bus.busy, dut.prio_r} !== {1'b1, 8'h56, 1'b0, 1'b0}) begin
            errors++; $display("FAIL idle_last_beat: got l=%b d=%h busy=%b prio=%b expected l=1 d=56 busy=0 prio=0",
                               bus.y_last, bus.y_data, bus.busy, dut.prio_r);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_async_reset();
        logic [4:0] obs;
        bus.y_ready  = 1'b1;
        bus.d0_valid = 1'b1;
        bus.d0_data  = 8'hC0;
        bus.d0_last  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if ({bus.busy, bus.y_valid} !== 2'b11) begin
            errors++; $display("FAIL arst_pre: got busy=%b yv=%b expected 1 1", bus.busy, bus.y_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        obs = {bus.y_valid, bus.busy, bus.d0_ready, bus.d1_ready, bus.sel};
        checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL arst_immediate: got %b expected 00000", obs); end
        checks++;
        if (bus.y_data !== 8'h00) begin errors++; $display("FAIL arst_ydata: got %h expected 00", bus.y_data); end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        test_contention(1'b0, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_contention(1'b0, "contend_a");
        test_single_beat();
        test_contention(1'b1, "contend_b");
        test_backpressure();
        test_idle_requester();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux21_arbiter.md
Name: mux21_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 mux datapath (S/D0/D1/Y, WIDTH bits) between two valid/ready requester streams.
- Grants are burst-locked: once a port wins, it keeps the mux until it sends a beat with last=1.
- Drives the mux select internally, registers the mux output into a one-entry output stage, and presents a single valid/ready stream downstream.
- Sits between two producers and a single consumer in the lab mux datapath.

Parameters:
- WIDTH, 8, data bit width of each requester and of the internal mux instance.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- d0_valid  input  1  port 0 beat valid.
- d0_data  input  WIDTH  port 0 beat data (mux D0).
- d0_last  input  1  port 0 final beat of burst.
- d0_ready  output  1  port 0 beat accepted this cycle when high together with d0_valid.
- d1_valid  input  1  port 1 beat valid.
- d1_data  input  WIDTH  port 1 beat data (mux D1).
- d1_last  input  1  port 1 final beat of burst.
- d1_ready  output  1  port 1 ready.
- y_valid  output  1  output beat valid (registered).
- y_data  output  WIDTH  output beat data (registered mux Y).
- y_last  output  1  output final-beat flag (registered).
- y_ready  input  1  downstream accepts the y beat when high with y_valid.
- sel  output  1  current mux select: 1 only in LOCK1, otherwise 0.
- busy  output  1  high in LOCK0 or LOCK1.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- While rst_n=0, with immediate effect:
  - state=IDLE, prio=0.
  - y_valid=0, y_data=0, y_last=0.
  - sel=0, busy=0, d0_ready=0, d1_ready=0.
- FSM states: IDLE, LOCK0, LOCK1.
- prio is an internal pointer to the preferred port. Reset value 0.
- IDLE:
  - d0_ready=d1_ready=0.
  - Only one valid asserted -> next state LOCK of that port.
  - Both valid asserted -> next state LOCK of port prio.
  - Neither valid -> stay IDLE.
  - Arbitration costs exactly one cycle; no beat transfers in IDLE.
- LOCKi:
  - di_ready = !y_valid || y_ready.
  - The other port's ready = 0.
  - sel = i.
  - A beat transfers when di_valid && di_ready. On that edge:
    - y_data = mux Y (di_data).
    - y_last = di_last.
    - y_valid = 1.
  - A transferred beat with di_last=1 -> next state IDLE, and prio is set to the other port. This applies even if the other port is not requesting.
  - di_valid low -> stay in LOCKi indefinitely; the grant is not revoked.
- Output stage:
  - y_valid clears on an edge with y_valid && y_ready when no new beat loads in that same cycle.
  - Simultaneous drain and load -> y_valid stays 1 and the new beat replaces the old one. This gives full throughput: one beat per cycle at steady state.
  - y_ready=0 with y_valid=1 -> y_data and y_last hold stable and di_ready=0.
- Latency:
  - di_valid rises in IDLE at edge n -> LOCKi after edge n+1.
  - The first beat is accepted at edge n+2 if y is empty, and is visible on y at edge n+2.
  - From a granted input, one cycle: input beat to y_valid.
- Single-beat burst (last on first beat): returns to IDLE. Back-to-back bursts therefore have one idle arbitration cycle between them.
- Reset mid-burst: any in-flight burst and any held y beat are discarded. No partial recovery.
- di_data and di_last are only sampled on a transfer. Values are don't-care otherwise.

Test Plan:
- Reset, then d0_valid=1, d0_data=8'hA5, d0_last=1, y_ready=1 -> sel=0, y_valid=1, y_data=A5, y_last=1 two cycles after request; state returns to IDLE and prio=1.
- Both ports request at once from reset, each with a 3-beat burst (d0: 01,02,03; d1: 11,12,13), y_ready=1 -> y sequence 01,02,03,11,12,13 with one gap cycle between bursts. d1_ready stays 0 during the d0 burst.
- Repeat the contention scenario a second time -> port 1 wins first, showing the round-robin alternation.
- Backpressure: LOCK0 with a 4-beat burst, y_ready=0 for 3 cycles mid-burst -> y_data held, d0_ready=0, no beat lost or duplicated; the total of 4 beats matches in order.
- Idle requester in lock: LOCK1 with d1_valid deasserted for 5 cycles while d0_valid=1 -> sel stays 1, d0_ready=0, busy=1 throughout.
- Asynchronous reset asserted mid-burst between edges -> y_valid, busy and the ready outputs drop immediately. After release, the next contention grants port 0 (prio=0).
